axi_ahb_write_ctrl: RTL and testbench

//   AXI write-channel front end of the AXI-to-AHB bridge. Accepts one AW burst plus its W beats,

---
 rtl/axi_ahb_write_if.sv | 68 ++++++
 rtl/axi_ahb_write_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_axi_ahb_write_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ahb_write_if.sv
// Bundle for the AXI write channel, the arbiter request/grant pair and the AHB master side
// of the write path. 'slave' is the controller view, 'master' is the driving environment.
interface axi_ahb_write_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic              h_clk_en;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  logic              w_req;
  logic              w_grant;

  logic              h_ready;
  logic              h_resp;
  logic [ADDR_W-1:0] h_addr;
  logic [1:0]        h_trans;
  logic [2:0]        h_size;
  logic [DATA_W-1:0] h_wdata;
  logic [STRB_W-1:0] h_wstrb;

  modport slave (
    input  h_clk_en,
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    input  bready,
    output bvalid, bresp, bid,
    output w_req,
    input  w_grant,
    input  h_ready, h_resp,
    output h_addr, h_trans, h_size, h_wdata, h_wstrb
  );

  modport master (
    output h_clk_en,
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    output bready,
    input  bvalid, bresp, bid,
    input  w_req,
    output w_grant,
    output h_ready, h_resp,
    input  h_addr, h_trans, h_size, h_wdata, h_wstrb
  );
endinterface

// File: rtl/axi_ahb_write_ctrl.sv
// AXI write front end of the AXI-to-AHB bridge: one AW burst in, one AHB NONSEQ single per
// granted beat out, HRESP errors folded into a single B response.
//
// state   | meaning
// S_IDLE  | awready high, waiting for a burst
// S_BURST | fetching W beats and issuing address phases
// S_DRAIN | last address phase accepted, waiting for its data phase
// S_RESP  | bvalid high until bready
module axi_ahb_write_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input logic             clk,
  input logic             reset_n,
  axi_ahb_write_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED   = 2'b00;
  localparam logic [1:0] BURST_WRAP    = 2'b10;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [8:0]        beats_left_q, beats_left_d;
  logic [8:0]        fetch_left_q, fetch_left_d;
  logic              err_q, err_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [STRB_W-1:0] buf_strb_q, buf_strb_d;
  logic              dp_valid_q, dp_valid_d;
  logic [DATA_W-1:0] dp_data_q, dp_data_d;
  logic [STRB_W-1:0] dp_strb_q, dp_strb_d;

  logic              wready_w;
  logic              aw_fire, w_fire, addr_acc, dp_done;
  logic [ADDR_W-1:0] incr, wrap_mask, addr_seq, addr_next;
  logic              wrap_ok;

  assign wready_w = (state_q == S_BURST) & ~buf_valid_q & (fetch_left_q != 9'd0);
  assign aw_fire  = bus.awvalid & (state_q == S_IDLE);
  assign w_fire   = bus.wvalid & wready_w;
  assign addr_acc = (state_q == S_BURST) & bus.h_clk_en & bus.w_grant & buf_valid_q & bus.h_ready;
  assign dp_done  = bus.h_clk_en & bus.h_ready & dp_valid_q;

  // WRAP only for power-of-two burst lengths; anything else degrades to INCR.
  always_comb begin
    incr      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    addr_seq  = addr_q + incr;
    wrap_ok   = (burst_q == BURST_WRAP) &&
                ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
    addr_next = addr_seq;
    if (burst_q == BURST_FIXED) begin
      addr_next = addr_q;
    end else if (wrap_ok) begin
      addr_next = (addr_q & ~wrap_mask) | (addr_seq & wrap_mask);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    id_d         = id_q;
    beats_left_d = beats_left_q;
    fetch_left_d = fetch_left_q;
    err_d        = err_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    buf_strb_d   = buf_strb_q;
    dp_valid_d   = dp_valid_q;
    dp_data_d    = dp_data_q;
    dp_strb_d    = dp_strb_q;

    case (state_q)
      S_IDLE: begin
        if (aw_fire) begin
          addr_d       = bus.awaddr;
          len_d        = bus.awlen;
          size_d       = bus.awsize;
          burst_d      = bus.awburst;
          id_d         = bus.awid;
          beats_left_d = {1'b0, bus.awlen} + 9'd1;
          fetch_left_d = {1'b0, bus.awlen} + 9'd1;
          err_d        = 1'b0;
          state_d      = S_BURST;
        end
      end
      S_BURST: begin
        if (addr_acc && (beats_left_q == 9'd1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dp_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.bready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_fire) begin
      buf_valid_d  = 1'b1;
      buf_data_d   = bus.wdata;
      buf_strb_d   = bus.wstrb;
      fetch_left_d = fetch_left_q - 9'd1;
    end

    if (dp_done) begin
      dp_valid_d = 1'b0;
      if (bus.h_resp) begin
        err_d = 1'b1;
      end
    end

    // A new address phase refills the data-phase register in the same HCLK edge
    // that retires the previous one, so dp_valid stays high across back-to-back beats.
    if (addr_acc) begin
      dp_valid_d   = 1'b1;
      dp_data_d    = buf_data_q;
      dp_strb_d    = buf_strb_q;
      buf_valid_d  = 1'b0;
      beats_left_d = beats_left_q - 9'd1;
      addr_d       = addr_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      beats_left_q <= '0;
      fetch_left_q <= '0;
      err_q        <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
      buf_strb_q   <= '0;
      dp_valid_q   <= 1'b0;
      dp_data_q    <= '0;
      dp_strb_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      id_q         <= id_d;
      beats_left_q <= beats_left_d;
      fetch_left_q <= fetch_left_d;
      err_q        <= err_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      buf_strb_q   <= buf_strb_d;
      dp_valid_q   <= dp_valid_d;
      dp_data_q    <= dp_data_d;
      dp_strb_q    <= dp_strb_d;
    end
  end

  assign bus.awready = (state_q == S_IDLE);
  assign bus.wready  = wready_w;
  assign bus.bvalid  = (state_q == S_RESP);
  assign bus.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
  assign bus.bid     = id_q;
  assign bus.w_req   = buf_valid_q & (state_q == S_BURST);
  assign bus.h_trans = (bus.w_grant && buf_valid_q && (state_q == S_BURST)) ? HTRANS_NONSEQ
                                                                             : HTRANS_IDLE;
  assign bus.h_addr  = addr_q;
  assign bus.h_size  = size_q;
  assign bus.h_wdata = dp_data_q;
  assign bus.h_wstrb = dp_strb_q;

endmodule

// File: tb/tb_axi_ahb_write_ctrl.sv
// Directed bench for axi_ahb_write_ctrl: bursts of each type, HRESP error, W gaps with HREADY
// stalls, gated HCLK with grant loss, and reset in the middle of a burst.
module tb_axi_ahb_write_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axi_ahb_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_ahb_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic grant_en = 1'b1;
  logic cen_all = 1'b1;
  logic cen_phase = 1'b0;
  assign bus.w_grant  = bus.w_req & grant_en;
  assign bus.h_clk_en = cen_all | cen_phase;

  logic [35:0] w_q[$];
  int          w_gap = 0;
  int          flush_req = 0;
  logic [31:0] addr_log[$];
  logic [35:0] data_log[$];
  logic [5:0]  b_log[$];
  int          stray = 0;
  int          ungranted = 0;
  int          err_beat = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strb_of(input int i);
    case (i % 3)
      0:       return 4'hF;
      1:       return 4'h3;
      default: return 4'hC;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cen_phase = ~cen_phase;
    end
  end

  // W channel driver: presents queued beats, idling w_gap cycles after each handshake.
  initial begin
    int  gap;
    int  seen;
    bit  fire;
    gap = 0;
    seen = 0;
    bus.wvalid = 1'b0;
    bus.wdata  = '0;
    bus.wstrb  = '0;
    forever begin
      @(negedge clk);
      fire = bus.wvalid && bus.wready && reset_n;
      @(posedge clk);
      #1;
      if (seen != flush_req) begin
        seen = flush_req;
        bus.wvalid = 1'b0;
        gap = 0;
        fire = 1'b0;
      end
      if (fire) begin
        bus.wvalid = 1'b0;
        gap = w_gap;
      end
      if (!bus.wvalid) begin
        if (gap > 0) gap--;
        else if (w_q.size() > 0) begin
          {bus.wstrb, bus.wdata} = w_q.pop_front();
          bus.wvalid = 1'b1;
        end
      end
    end
  end

  // Bus monitor, sampled mid-cycle: logs what the next rising edge will accept,
  // and drives HRESP for the data phase of beat err_beat.
  initial begin
    bit          dp_pend;
    int          dp_idx;
    logic [31:0] prev_addr;
    bit          prev_valid;
    bit          prev_move;
    dp_pend = 0;
    dp_idx = 0;
    prev_addr = '0;
    prev_valid = 0;
    prev_move = 0;
    bus.h_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        dp_pend = 0;
        prev_valid = 0;
        bus.h_resp = 1'b0;
      end else begin
        bus.h_resp = dp_pend && (dp_idx == err_beat);
        if (prev_valid && (bus.h_addr !== prev_addr) && !prev_move) stray++;
        prev_addr  = bus.h_addr;
        prev_valid = 1;
        prev_move  = (bus.awvalid && bus.awready) ||
                     (bus.h_clk_en && bus.h_ready && bus.h_trans == 2'b10);
        if (bus.h_trans == 2'b10 && !bus.w_grant) ungranted++;
        if (bus.h_trans != 2'b00 && !bus.w_req) ungranted++;
        if (bus.h_clk_en && bus.h_ready) begin
          if (dp_pend) data_log.push_back({bus.h_wstrb, bus.h_wdata});
          dp_pend = (bus.h_trans == 2'b10);
          if (dp_pend) begin
            addr_log.push_back(bus.h_addr);
            dp_idx = addr_log.size();
          end
        end
        if (bus.bvalid && bus.bready) b_log.push_back({bus.bresp, bus.bid});
      end
    end
  end

  task automatic push_beats(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) w_q.push_back({strb_of(i), base + 32'(i)});
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = size;
    bus.awburst = burst;
    bus.awid    = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.awready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    chk("aw_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_addrs(input int n);
    for (int i = 0; i < 200; i++) begin
      if (addr_log.size() >= n) break;
      @(posedge clk);
      #1;
    end
    chk("addr_phase_reached", 64'(addr_log.size() >= n), 64'd1);
  endtask

  task automatic wait_b();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (b_log.size() > 0) break;
    end
    @(posedge clk);
    #1;
    chk("b_count", 64'(b_log.size()), 64'd1);
  endtask

  task automatic check_burst(input string tag, input int n, input logic [31:0] exp_a[8],
                             input logic [31:0] base, input logic [1:0] resp, input logic [3:0] id);
    logic [63:0] obs;
    chk({tag, "_naddr"}, 64'(addr_log.size()), 64'(n));
    chk({tag, "_ndata"}, 64'(data_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      obs = (i < addr_log.size()) ? 64'(addr_log[i]) : 'x;
      chk($sformatf("%s_addr%0d", tag, i), obs, 64'(exp_a[i]));
      obs = (i < data_log.size()) ? 64'(data_log[i]) : 'x;
      chk($sformatf("%s_data%0d", tag, i), obs, 64'({strb_of(i), base + 32'(i)}));
    end
    obs = (b_log.size() > 0) ? 64'(b_log[0]) : 'x;
    chk({tag, "_bresp_bid"}, obs, 64'({resp, id}));
    addr_log.delete();
    data_log.delete();
    b_log.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.awvalid = 1'b0;
    bus.awaddr  = '0;
    bus.awlen   = '0;
    bus.awsize  = '0;
    bus.awburst = '0;
    bus.awid    = '0;
    bus.bready  = 1'b1;
    bus.h_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(bus.awready), 64'd1);
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_bresp", 64'(bus.bresp), 64'd0);
    chk("rst_bid", 64'(bus.bid), 64'd0);
    chk("rst_w_req", 64'(bus.w_req), 64'd0);
    chk("rst_h_trans", 64'(bus.h_trans), 64'd0);
    chk("rst_h_addr", 64'(bus.h_addr), 64'd0);
    chk("rst_h_wdata", 64'(bus.h_wdata), 64'd0);
    chk("rst_h_wstrb", 64'(bus.h_wstrb), 64'd0);
    chk("rst_h_size", 64'(bus.h_size), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // INCR 4 x 4 bytes
    push_beats(4, 32'hA000_0000);
    send_aw(32'h100, 8'd3, 3'd2, 2'b01, 4'h5);
    wait_b();
    check_burst("incr", 4, '{32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0},
                32'hA000_0000, 2'b00, 4'h5);

    // WRAP 4 x 4 bytes starting mid-window
    push_beats(4, 32'hB000_0000);
    send_aw(32'h108, 8'd3, 3'd2, 2'b10, 4'h9);
    wait_b();
    check_burst("wrap", 4, '{32'h108, 32'h10C, 32'h100, 32'h104, 0, 0, 0, 0},
                32'hB000_0000, 2'b00, 4'h9);

    // HRESP error on beat 2 still issues all beats, SLVERR once
    err_beat = 2;
    push_beats(4, 32'hC000_0000);
    send_aw(32'h200, 8'd3, 3'd2, 2'b01, 4'h3);
    wait_b();
    err_beat = 0;
    check_burst("err", 4, '{32'h200, 32'h204, 32'h208, 32'h20C, 0, 0, 0, 0},
                32'hC000_0000, 2'b10, 4'h3);

    // FIXED with 5-cycle W gaps and a 3-cycle HREADY stall on the first data phase
    w_gap = 5;
    push_beats(4, 32'hD000_0000);
    send_aw(32'h300, 8'd3, 3'd2, 2'b00, 4'hC);
    wait_addrs(1);
    bus.h_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_wdata_hold", 64'(bus.h_wdata), 64'h0000_0000_D000_0000);
    @(posedge clk);
    #1;
    bus.h_ready = 1'b1;
    wait_b();
    w_gap = 0;
    check_burst("gap", 4, '{32'h300, 32'h300, 32'h300, 32'h300, 0, 0, 0, 0},
                32'hD000_0000, 2'b00, 4'hC);

    // HCLK enable every other cycle, grant withdrawn for two HCLK edges mid-burst
    cen_all = 1'b0;
    push_beats(4, 32'hE000_0000);
    send_aw(32'h400, 8'd3, 3'd1, 2'b01, 4'h6);
    wait_addrs(2);
    grant_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("nogrant_h_trans", 64'(bus.h_trans), 64'd0);
    chk("nogrant_h_addr", 64'(bus.h_addr), 64'h404);
    chk("nogrant_w_req", 64'(bus.w_req), 64'd1);
    chk("nogrant_h_size", 64'(bus.h_size), 64'd1);
    chk("nogrant_addr_count", 64'(addr_log.size()), 64'd2);
    grant_en = 1'b1;
    wait_b();
    cen_all = 1'b1;
    check_burst("cen", 4, '{32'h400, 32'h402, 32'h404, 32'h406, 0, 0, 0, 0},
                32'hE000_0000, 2'b00, 4'h6);

    // Reset after the first beat of an 8-beat burst
    push_beats(8, 32'hF000_0000);
    send_aw(32'h500, 8'd7, 3'd2, 2'b01, 4'hA);
    wait_addrs(1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_awready", 64'(bus.awready), 64'd1);
    chk("mid_rst_wready", 64'(bus.wready), 64'd0);
    chk("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("mid_rst_w_req", 64'(bus.w_req), 64'd0);
    chk("mid_rst_h_trans", 64'(bus.h_trans), 64'd0);
    chk("mid_rst_h_addr", 64'(bus.h_addr), 64'd0);
    chk("mid_rst_h_wdata", 64'(bus.h_wdata), 64'd0);
    chk("mid_rst_bid", 64'(bus.bid), 64'd0);
    w_q.delete();
    flush_req++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("aborted_no_b", 64'(b_log.size()), 64'd0);
    addr_log.delete();
    data_log.delete();
    b_log.delete();

    // WRAP of two beats right after the reset
    push_beats(2, 32'h1234_0000);
    send_aw(32'h604, 8'd1, 3'd2, 2'b10, 4'hF);
    wait_b();
    check_burst("wrap2", 2, '{32'h604, 32'h600, 0, 0, 0, 0, 0, 0},
                32'h1234_0000, 2'b00, 4'hF);

    // WRAP with a non power-of-two length advances like INCR
    push_beats(3, 32'h5678_0000);
    send_aw(32'h708, 8'd2, 3'd2, 2'b10, 4'h1);
    wait_b();
    check_burst("wrap3", 3, '{32'h708, 32'h70C, 32'h710, 0, 0, 0, 0, 0},
                32'h5678_0000, 2'b00, 4'h1);

    chk("no_stray_addr_change", 64'(stray), 64'd0);
    chk("no_ungranted_nonseq", 64'(ungranted), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
